// File: rtl/sequential_signed_divider.sv
`default_nettype none
// ============================================================================
// sequential_signed_divider
//   Restoring signed divider: one quotient bit per clock, start/done handshake.
//   Revision: 1.0
// ============================================================================
module sequential_signed_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign abs_dividend = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign abs_divisor  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

  // The settled partial remainder is always below the divisor, so WIDTH bits
  // hold it; only the shifted trial value needs the extra bit.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    zero_d        = zero_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d     = '0;
          quo_d     = abs_dividend;
          dvs_d     = abs_divisor;
          neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d = dividend[WIDTH-1];
          zero_d    = (divisor == '0);
          cnt_d     = CW'(WIDTH);
          state_d   = CALC;
        end
      end
      CALC: begin
        // quo_q doubles as the dividend shifter: its MSB feeds the remainder.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        if (zero_q) begin
          quotient_d = '1;
        end else begin
          quotient_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        end
        remainder_d   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        div_by_zero_d = zero_q;
        done_d        = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      zero_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      zero_q        <= zero_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      done_q        <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_sequential_signed_divider.sv
`default_nettype none
// ============================================================================
// tb_sequential_signed_divider
//   Scoreboard bench: expected results queued at acceptance, popped on done.
//   Revision: 1.0
// ============================================================================
module tb_sequential_signed_divider;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  sequential_signed_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   sa;
    int   sb_i;
    int   qi;
    int   ri;
    sa   = int'($signed(a));
    sb_i = int'($signed(b));
    if (sb_i == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      qi    = sa / sb_i;
      ri    = sa % sb_i;
      e.q   = qi[WIDTH-1:0];
      e.r   = ri[WIDTH-1:0];
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      check("sb_nonempty_at_done", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", {24'd0, quotient}, {24'd0, e.q});
        check("remainder", {24'd0, remainder}, {24'd0, e.r});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 30);
  endtask

  task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    int busy_cnt;
    logic [WIDTH-1:0] q_hold;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    sb.push_back(model(a, b));
    #1;
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
    busy_cnt = busy ? 1 : 0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (busy) busy_cnt++;
    end while (!done && n < 30);
    check("latency", n, 9);
    check("busy_cycles", busy_cnt, 9);
    check("busy_low_at_done", {31'd0, busy}, 32'd0);
    q_hold = quotient;
    @(posedge clk);
    #1;
    check("done_single_pulse", {31'd0, done}, 32'd0);
    check("quotient_hold", {24'd0, quotient}, {24'd0, q_hold});
  endtask

  initial begin
    int n;
    int m;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", {24'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    run_div(8'd100, 8'd7);
    run_div(8'h9C, 8'd7);
    run_div(8'd100, 8'hF9);
    run_div(8'h9C, 8'hF9);
    run_div(8'h80, 8'hFF);
    run_div(8'h80, 8'h01);
    run_div(8'd5, 8'd0);
    run_div(8'd9, 8'd3);
    run_div(8'h80, 8'd0);
    run_div(8'h7F, 8'h80);
    run_div(8'h00, 8'hFF);

    // start mid-CALC with other operands must be ignored
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk);
    sb.push_back(model(8'd100, 8'd7));
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; dividend = 8'd50; divisor = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    check("ignored_start_done_seen", {31'd0, done}, 32'd1);
    repeat (15) @(posedge clk);
    check("ignored_start_sb_empty", sb.size(), 0);

    // start held through the done cycle launches the next division
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk);
    sb.push_back(model(8'd100, 8'd7));
    #1 dividend = 8'd9; divisor = 8'd3;
    wait_done(n);
    check("b2b_first_latency", n, 9);
    @(posedge clk);
    sb.push_back(model(8'd9, 8'd3));
    #1 start = 1'b0;
    check("b2b_busy_relaunch", {31'd0, busy}, 32'd1);
    wait_done(m);
    check("b2b_done_gap", m + 1, 10);
    repeat (2) @(posedge clk);

    // reset during CALC aborts the division
    @(negedge clk);
    start = 1'b1; dividend = 8'd77; divisor = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", {24'd0, quotient}, 32'd0);
    check("abort_remainder", {24'd0, remainder}, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    run_div(8'd9, 8'd3);

    for (int i = 0; i < 1500; i++) begin
      run_div(WIDTH'($urandom), WIDTH'($urandom_range(0, 255)));
    end

    repeat (3) @(posedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
